inst_fetch_unit: RTL and testbench
==================================

Name: inst_fetch_unit

Overview:
Initiator side of the instruction-memory interface. It owns the program counter and drives im_addr into the combinational instruction memory. It captures the returned im_inst together with its PC into a small in-order queue, and presents the queued instructions to decode over a valid/ready handshake. Redirects from execute (branch/jump) flush the queue and reload the PC.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
DEPTH, 2, queue entries (power of two, >=2)
NOP_INST, 32'h0000_0013, value driven on if_inst while queue empty

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
im_addr  output  32  fetch address to instruction memory; equals current PC
im_inst  input  32  instruction word returned combinationally for im_addr
if_valid  output  1  queue head holds a valid instruction
if_inst  output  32  instruction at queue head (NOP_INST when empty)
if_pc  output  32  PC of queue head (0 when empty)
id_ready  input  1  decode accepts head this cycle
redirect_valid  input  1  execute requests PC change
redirect_pc  input  32  redirect target; bits [1:0] forced to 0
fetch_pc  output  32  current PC register (debug/trace)

Behaviour:
- clk is the only clock. rst is synchronous and active-high.
- Reset values: pc=RESET_PC, so im_addr=fetch_pc=RESET_PC. Queue count=0, head=tail=0. if_valid=0, if_inst=NOP_INST, if_pc=0.
- im_addr = pc at all times (combinational from the pc register). The memory returns im_inst in the same cycle.
- pop = if_valid && id_ready.
- fetch = !redirect_valid && (count < DEPTH || pop).
  - A full queue still fetches when a pop occurs in the same cycle.
- On fetch:
  - Write {pc, im_inst} at tail; tail++ (wraps mod DEPTH).
  - pc <= pc + 4, 32-bit wrap: 32'hFFFF_FFFC -> 32'h0000_0000.
- On pop: head++ (wraps mod DEPTH).
- count update: count <= count + fetch - pop. Simultaneous push and pop leaves count unchanged.
- Latency: an instruction fetched in cycle N is visible on if_valid/if_inst in cycle N+1 at the earliest. There is no bypass from im_inst to if_inst.
- Steady state with id_ready=1 and no redirects: one instruction per cycle, with if_pc incrementing by 4 each cycle.
- Backpressure: while id_ready=0, head and its outputs are held stable. The queue fills to DEPTH, after which pc stops advancing and im_addr holds.
- Redirect (redirect_valid=1), same edge:
  - count<=0, head<=0, tail<=0.
  - pc <= {redirect_pc[31:2], 2'b00}.
  - No fetch occurs that cycle. A pop that cycle is still a valid handoff to decode.
  - First redirected instruction appears on if_valid two cycles after the redirect edge: fetched in cycle N+1, valid in N+2.
- Priority: rst > redirect_valid > fetch/pop.
  - Reset mid-stream discards all queued entries regardless of id_ready or redirect.
- Consecutive redirects: the last one wins, and no fetch occurs during any redirect cycle.
- Queue outputs are registered storage read at head. if_valid = (count != 0).
- Queue storage is not reset; only pointers and count are reset.
- No X propagation on outputs when empty: drive NOP_INST and 0.

Test Plan:
1. Reset then release, memory[0..3]=0x0a800093, 0x00102023, 0x00002c03, 0x001c0c33, id_ready=1 -> im_addr 0,4,8,C on consecutive cycles. if_valid rises 1 cycle after release. if_pc/if_inst = 0/0x0a800093, 4/0x00102023, 8/0x00002c03, C/0x001c0c33 on consecutive cycles.
2. id_ready=0 from start for 5 cycles -> count saturates at 2 and im_addr holds at 0x8. if_pc stays 0x0 with if_inst 0x0a800093 throughout. Raising id_ready resumes the stream with if_pc 0x0, 0x4, 0x8 with no gap or duplicate.
3. Redirect while queue full (redirect_pc=0x14) in the same cycle as a pop -> the popped entry is accepted. The queue empties next cycle with if_valid=0. im_addr=0x14 next cycle, and if_pc=0x14 with if_inst=0x00a00513 two cycles after the redirect.
4. redirect_pc=0x23 -> pc loads 0x20. Two redirects back-to-back (0x10 then 0x28) -> only 0x28 is fetched, and the first valid output has if_pc=0x28.
5. Redirect to 0xFFFF_FFFC, id_ready=1 -> fetch_pc sequence 0xFFFF_FFFC, 0x0000_0000, 0x0000_0004.
6. Assert rst for 1 cycle while the queue holds 2 entries and redirect_valid=1 -> next cycle: if_valid=0, if_inst=0x00000013, im_addr=RESET_PC, and the redirect is ignored.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: owns the PC, reads a combinational instruction
// memory and feeds decode from a small in-order queue of {pc, inst} entries.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] im_addr,
    input  logic [31:0] im_inst,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    input  logic        id_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] fetch_pc
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [31:0]   pc;
    logic [31:0]   inst_q [DEPTH];
    logic [31:0]   pc_q   [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic          pop;
    logic          fetch;
    logic          unused_redirect_lsbs;

    // Handshake: the head moves to decode on a rising edge where if_valid and
    // id_ready are both high; while id_ready is low the head and its outputs hold.
    assign pop   = if_valid && id_ready;
    assign fetch = !redirect_valid && ((count < FULL) || pop);

    assign im_addr  = pc;
    assign fetch_pc = pc;
    assign if_valid = (count != '0);
    assign if_inst  = if_valid ? inst_q[head] : NOP_INST;
    assign if_pc    = if_valid ? pc_q[head] : 32'h0000_0000;

    // Targets are word aligned; the low bits of redirect_pc are ignored.
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            pc    <= RESET_PC;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (redirect_valid) begin
            pc    <= {redirect_pc[31:2], 2'b00};
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (fetch) begin
                pc   <= pc + 32'd4;
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            case ({fetch, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage carries no reset; count alone decides what is live.
    always_ff @(posedge clk) begin
        if (fetch) begin
            inst_q[tail] <= im_inst;
            pc_q[tail]   <= pc;
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: memory model on im_addr, scoreboard of {pc, inst}
// pairs expected at decode, plus direct checks of PC and flag behaviour.
module tb_inst_fetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] im_addr;
    logic [31:0] im_inst;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        id_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] fetch_pc;

    logic [63:0] exp_q[$];
    int          n_cmp;
    int          n_err;

    inst_fetch_unit #(
        .RESET_PC(32'h0000_0000),
        .DEPTH(2),
        .NOP_INST(32'h0000_0013)
    ) dut (
        .clk(clk),
        .rst(rst),
        .im_addr(im_addr),
        .im_inst(im_inst),
        .if_valid(if_valid),
        .if_inst(if_inst),
        .if_pc(if_pc),
        .id_ready(id_ready),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .fetch_pc(fetch_pc)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        case (addr)
            32'h0000_0000: return 32'h0a80_0093;
            32'h0000_0004: return 32'h0010_2023;
            32'h0000_0008: return 32'h0000_2c03;
            32'h0000_000C: return 32'h001c_0c33;
            32'h0000_0014: return 32'h00a0_0513;
            default:       return {addr[31:2], 2'b11} ^ 32'h1357_0000;
        endcase
    endfunction

    assign im_inst = mem_word(im_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc);
        exp_q.push_back({pc, mem_word(pc)});
    endtask

    // One clock: consume the head into the scoreboard if handed off, then advance.
    task automatic cycle();
        logic [63:0] e;
        if (if_valid && id_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_pop: got pc %h expected no handoff", if_pc);
            end else begin
                e = exp_q.pop_front();
                chk("pop_pc", if_pc, e[63:32]);
                chk("pop_inst", if_inst, e[31:0]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        id_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        cycle();
        cycle();
        chk("rst_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_inst", if_inst, 32'h0000_0013);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_addr", im_addr, 32'h0);
        chk("rst_fetch_pc", fetch_pc, 32'h0);

        // 1: streaming
        rst = 1'b0;
        id_ready = 1'b1;
        for (int i = 0; i < 5; i++) push_exp(32'(4 * i) & 32'hC);
        for (int i = 0; i < 4; i++) begin
            chk("t1_addr", im_addr, 32'(4 * i));
            chk("t1_valid", {31'b0, if_valid}, (i == 0) ? 32'd0 : 32'd1);
            cycle();
        end
        void'(exp_q.pop_back());
        cycle();
        chk("t1_sb_empty", 32'(exp_q.size()), 32'd0);

        // 2: backpressure from start
        id_ready = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        push_exp(32'h0);
        push_exp(32'h4);
        push_exp(32'h8);
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("t2_hold_pc", if_pc, 32'h0);
            chk("t2_hold_inst", if_inst, 32'h0a80_0093);
        end
        chk("t2_addr_hold", im_addr, 32'h8);
        chk("t2_fetch_pc", fetch_pc, 32'h8);
        id_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("t2_valid", {31'b0, if_valid}, 32'd1);
            cycle();
        end
        chk("t2_sb_empty", 32'(exp_q.size()), 32'd0);

        // 3: redirect on a full queue with a simultaneous pop
        push_exp(32'hC);
        redirect_valid = 1'b1;
        redirect_pc = 32'h14;
        cycle();
        redirect_valid = 1'b0;
        chk("t3_valid_flush", {31'b0, if_valid}, 32'd0);
        chk("t3_addr", im_addr, 32'h14);
        push_exp(32'h14);
        cycle();
        chk("t3_valid_back", {31'b0, if_valid}, 32'd1);
        cycle();
        chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);

        // 4: unaligned target and back-to-back redirects
        id_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h23;
        cycle();
        chk("t4_align", fetch_pc, 32'h20);
        chk("t4_valid0", {31'b0, if_valid}, 32'd0);
        redirect_pc = 32'h10;
        cycle();
        redirect_pc = 32'h28;
        cycle();
        chk("t4_last_wins", fetch_pc, 32'h28);
        chk("t4_valid1", {31'b0, if_valid}, 32'd0);
        redirect_valid = 1'b0;
        id_ready = 1'b1;
        push_exp(32'h28);
        push_exp(32'h2C);
        push_exp(32'h30);
        cycle();
        cycle();
        cycle();

        // 5: PC wraps at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        cycle();
        redirect_valid = 1'b0;
        chk("t5_pc0", fetch_pc, 32'hFFFF_FFFC);
        chk("t4_sb_empty", 32'(exp_q.size()), 32'd0);
        cycle();
        chk("t5_pc1", fetch_pc, 32'h0000_0000);
        push_exp(32'hFFFF_FFFC);
        push_exp(32'h0);
        cycle();
        chk("t5_pc2", fetch_pc, 32'h0000_0004);
        cycle();

        // 6: reset beats a concurrent redirect with a full queue
        id_ready = 1'b0;
        cycle();
        cycle();
        chk("t6_full_hold", fetch_pc, 32'hC);
        chk("t6_head", if_pc, 32'h4);
        rst = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        cycle();
        rst = 1'b0;
        redirect_valid = 1'b0;
        chk("t6_valid", {31'b0, if_valid}, 32'd0);
        chk("t6_inst", if_inst, 32'h0000_0013);
        chk("t6_if_pc", if_pc, 32'h0);
        chk("t6_addr", im_addr, 32'h0);
        id_ready = 1'b1;
        push_exp(32'h0);
        cycle();
        cycle();
        chk("final_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
